// File: rtl/level_sensor_filter.sv
// Input conditioning for the tank-level FSM: 2-flop synchronisers, per-channel
// debounce, float plausibility check and a sticky overload/sensor fault latch.
module level_sensor_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] level_raw,
    input  logic [1:0] fault_raw,
    input  logic       clr_fault,
    output logic [1:0] A,
    output logic [1:0] P,
    output logic       stable
);

    localparam int NUM_CH = 4;
    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    // Channel map: [1:0] = level floats, [2] = dry-run, [3] = motor overload
    logic [NUM_CH-1:0]            raw;
    logic [NUM_CH-1:0]            s1_q;
    logic [NUM_CH-1:0]            s2_q;
    logic [NUM_CH-1:0]            deb_q;
    logic [NUM_CH-1:0]            deb_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_CH-1:0]            settled;

    logic       latch_q;
    logic       latch_d;
    logic       implausible_d;
    logic       set_d;
    logic [1:0] a_q;
    logic [1:0] a_d;
    logic [1:0] p_q;
    logic [1:0] p_d;

    assign raw = {fault_raw, level_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // A single sample back at the debounced value drops the count to zero.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        settled = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (s2_q[ch] != deb_q[ch]) begin
                if (cnt_q[ch] == CNT_MAX) begin
                    deb_d[ch] = s2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
            settled[ch] = (cnt_q[ch] == '0) && (s2_q[ch] == deb_q[ch]);
        end
    end

    always_comb begin
        implausible_d = (deb_d[1:0] == 2'b10);
        set_d         = deb_d[3] | implausible_d;
        latch_d       = set_d | (latch_q & ~clr_fault);
        a_d           = deb_d[1:0];
        if (latch_d) begin
            p_d = 2'b10;
        end else if (deb_d[2]) begin
            p_d = 2'b01;
        end else begin
            p_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q   <= '0;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            a_q     <= 2'b00;
            p_q     <= 2'b00;
        end else begin
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            a_q     <= a_d;
            p_q     <= p_d;
        end
    end

    assign A      = a_q;
    assign P      = p_q;
    assign stable = &settled;

endmodule

// File: tb/tb_level_sensor_filter.sv
// Directed bench for level_sensor_filter with DEB_CYCLES = 4.
module tb_level_sensor_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] level_raw;
    logic [1:0] fault_raw;
    logic       clr_fault;
    logic [1:0] A;
    logic [1:0] P;
    logic       stable;

    int errors = 0;
    int checks = 0;

    level_sensor_filter #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .level_raw (level_raw),
        .fault_raw (fault_raw),
        .clr_fault (clr_fault),
        .A         (A),
        .P         (P),
        .stable    (stable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clr_pulse();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        level_raw = 2'b00;
        fault_raw = 2'b00;
        clr_fault = 1'b0;
        repeat (3) tick();
        chk("rst_A", A, 2'b00);
        chk("rst_P", P, 2'b00);
        chk("rst_stable", {1'b0, stable}, 2'b01);
        reset = 1'b0;

        // 1: idle
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("idle_A", A, 2'b00);
            chk("idle_P", P, 2'b00);
            chk("idle_stable", {1'b0, stable}, 2'b01);
        end

        // 2: clean step 00 -> 01, flips on edge 6
        level_raw = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("step_A", A, (k == 6) ? 2'b01 : 2'b00);
            chk("step_stable", {1'b0, stable}, (k >= 2 && k <= 5) ? 2'b00 : 2'b01);
            chk("step_P", P, 2'b00);
        end

        // 3: back to 00, then 3-cycle glitch (rejected) and 4-cycle pulse (passed)
        level_raw = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("fall_A", A, (k == 6) ? 2'b00 : 2'b01);
        end
        level_raw = 2'b01;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 3) level_raw = 2'b00;
            chk("pulse3_A", A, 2'b00);
        end
        level_raw = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) level_raw = 2'b00;
            chk("pulse4_A", A, (k >= 6 && k <= 9) ? 2'b01 : 2'b00);
        end

        // 4: tank full, dry-run fault comes and goes without a clear
        level_raw = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("full_A", A, (k == 6) ? 2'b11 : 2'b00);
        end
        fault_raw = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("dry_P", P, (k == 6) ? 2'b01 : 2'b00);
        end
        fault_raw = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("dry_clear_P", P, (k == 6) ? 2'b00 : 2'b01);
        end

        // 5: overload outranks dry-run and is sticky
        fault_raw = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("ovl_P", P, (k == 6) ? 2'b10 : 2'b00);
        end
        fault_raw = 2'b00;
        repeat (2) tick();
        clr_pulse();
        chk("clr_while_ovl_P", P, 2'b10);
        repeat (5) tick();
        chk("ovl_held_P", P, 2'b10);
        clr_pulse();
        chk("ovl_cleared_P", P, 2'b00);

        fault_raw = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("ovl2_pre_P", P, 2'b00);
        end
        clr_pulse();
        chk("set_wins_P", P, 2'b10);
        tick();
        chk("set_wins_hold_P", P, 2'b10);
        fault_raw = 2'b00;
        repeat (6) tick();
        chk("ovl2_held_P", P, 2'b10);
        clr_pulse();
        chk("ovl2_cleared_P", P, 2'b00);

        // 6: implausible floats latch a fault
        level_raw = 2'b10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("impl_A", A, (k == 6) ? 2'b10 : 2'b11);
            chk("impl_P", P, (k == 6) ? 2'b10 : 2'b00);
        end
        level_raw = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("impl_back_A", A, (k == 6) ? 2'b11 : 2'b10);
            chk("impl_latched_P", P, 2'b10);
        end
        clr_pulse();
        chk("impl_cleared_P", P, 2'b00);

        level_raw = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("low_A", A, (k == 6) ? 2'b01 : 2'b11);
            chk("low_P", P, 2'b00);
        end

        // reset mid-debounce of 01 -> 00
        level_raw = 2'b00;
        repeat (4) tick();
        chk("mid_stable", {1'b0, stable}, 2'b00);
        chk("mid_A", A, 2'b01);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_A", A, 2'b00);
        chk("async_rst_P", P, 2'b00);
        chk("async_rst_stable", {1'b0, stable}, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("post_rst_A", A, 2'b00);
            chk("post_rst_stable", {1'b0, stable}, 2'b01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
